data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning word width in bits; legal values are multiples of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width; depth is 2^ADDR_W words.
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, meaning extra access cycles; legal range is 0..7.
REQ-004 Clock  in  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-005 Reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 req  in  1  SHALL be the access request.
REQ-007 wren  in  1  SHALL select write (1) or read (0).
REQ-008 be  in  DATA_W/8  SHALL be the byte enables for writes, with bit i covering Din[8i+7:8i].
REQ-009 Address  in  ADDR_W  SHALL be the word address.
REQ-010 Din  in  DATA_W  SHALL be the write data.
REQ-011 ready  out  1  SHALL be high only when the block can accept a request.
REQ-012 ack  out  1  SHALL be a one-cycle completion pulse.
REQ-013 Q  out  DATA_W  SHALL be the data returned with ack.

Function
REQ-014 The FSM SHALL have exactly four states: CLEAR, IDLE, WAIT and DONE.
REQ-015 ready SHALL equal (state==IDLE) and SHALL be decoded from state only.
REQ-016 In CLEAR, the block SHALL write zero to mem[clr_cnt] on each edge, where clr_cnt counts 0..2^ADDR_W-1; after the last word it SHALL go to IDLE, so the clear takes exactly 2^ADDR_W cycles.
REQ-017 In IDLE with req=1, the block SHALL latch Address, wren, be and Din, load wcnt=WAIT_STATES, and go to WAIT.
REQ-018 In IDLE with req=0, the block SHALL remain in IDLE.
REQ-019 req SHALL be ignored outside IDLE; the requester holds req until it sees ready.
REQ-020 In WAIT with wcnt!=0, the block SHALL decrement wcnt and remain in WAIT.
REQ-021 In WAIT with wcnt==0, the block SHALL perform the access, set ack=1 and go to DONE.
REQ-022 In DONE, the block SHALL set ack=0 and return to IDLE.
REQ-023 ack SHALL rise WAIT_STATES+1 edges after the accepting edge.
REQ-024 Peak throughput SHALL be one access per WAIT_STATES+3 cycles.
REQ-025 A write SHALL update only the enabled bytes, and Q SHALL return the merged post-write word (write-through).
REQ-026 A write with be=0 SHALL leave memory unchanged, and Q SHALL return the current word; ack SHALL still pulse.
REQ-027 A read SHALL return mem[latched Address] on Q.
REQ-028 Q SHALL hold its value until the next ack.
REQ-029 All 2^ADDR_W addresses SHALL be valid; there is no out-of-range condition.
REQ-030 A read immediately following a write to the same address SHALL return the new data.

Reset
REQ-031 Reset SHALL force state=CLEAR, clr_cnt=0, wcnt=0, ack=0 and Q=0, which makes ready=0.
REQ-032 Reset asserted mid-access SHALL abort it: the pending write is discarded, no ack is issued, and a full clear follows.
REQ-033 Reset held high SHALL keep the block in CLEAR with clr_cnt=0.

Configuration
REQ-034 With DMEM_PARITY_EN defined, each byte SHALL store an even-parity bit computed on write.
REQ-035 With DMEM_PARITY_EN defined, output parity_err (1 bit) SHALL pulse with ack when any read byte's parity mismatches, and SHALL be 0 otherwise and at reset.
REQ-036 With DMEM_PARITY_EN defined, input par_flip (1 bit), sampled with the request, SHALL invert the stored parity of byte 0 on that write.
REQ-037 With DMEM_PARITY_EN defined, CLEAR SHALL write parity 0.
REQ-038 Without DMEM_PARITY_EN, parity_err, par_flip and the parity storage SHALL be absent.

Structure
REQ-039 Package data_mem_pkg SHALL hold the state enum, the default parameter constants and the byte-parity function.
REQ-040 Sub-module data_mem_array SHALL contain the storage, with one byte-enabled write port and one read port; the FSM, counters and output registers SHALL stay in data_mem_ctrl.

Verification
REQ-041 Deassert Reset -> ready=0 for exactly 16 cycles (ADDR_W=4), then ready=1; reads of addresses 0..15 -> Q=0x0000.
REQ-042 WAIT_STATES=1: write 0xBEEF to address 3, be=11 -> ack 2 edges after acceptance, Q=0xBEEF; a subsequent read of address 3 -> Q=0xBEEF.
REQ-043 Address 3 holds 0xBEEF; write 0x1234 with be=01 -> Q=0xBE34; then be=00 -> Q=0xBE34 and ack still pulses.
REQ-044 Assert Reset while in WAIT during a write of 0xAAAA to address 5 -> no ack, full clear, and address 5 reads 0x0000.
REQ-045 WAIT_STATES=0 with back-to-back reads to addresses 15 and 0 -> each ack 1 edge after acceptance, with 3 cycles between accepts.
REQ-046 DMEM_PARITY_EN defined: write 0x00FF to address 2 with par_flip=1, then read address 2 -> parity_err=1 with ack; write again with par_flip=0 -> parity_err=0.

Source files
------------

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pkg
// Purpose  : Shared types and constants for the data memory controller:
//            FSM state encoding, default parameter values and the byte
//            even-parity helper used when DMEM_PARITY_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
package data_mem_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_WAIT_STATES = 1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_array
// Purpose  : Word storage split into byte lanes, one byte-enabled
//            synchronous write port and one asynchronous read port.
//            LANE_W is 8, or 9 when the controller keeps a parity bit.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NBYTES = DEF_DATA_W / 8,
  parameter int LANE_W = 8
) (
  input  logic                     Clock,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [NBYTES-1:0]        wbe,
  input  logic [NBYTES*LANE_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [NBYTES*LANE_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    logic [LANE_W-1:0] r_mem [DEPTH];

    // Byte lane write, gated by its own enable.
    always_ff @(posedge Clock) begin
      if (we && wbe[i]) begin
        r_mem[waddr] <= wdata[i*LANE_W +: LANE_W];
      end
    end

    assign rdata[i*LANE_W +: LANE_W] = r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Wait-state data memory controller. Clears the array after
//            reset, then serves one byte-enabled read/write per
//            WAIT_STATES+3 cycles with a one-cycle ack and write-through Q.
// Options  : DMEM_PARITY_EN - per-byte even parity, par_flip and parity_err.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                req,
  input  logic                wren,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [DATA_W-1:0]   Din,
  output logic                ready,
  output logic                ack,
  output logic [DATA_W-1:0]   Q
`ifdef DMEM_PARITY_EN
  ,
  input  logic                par_flip,
  output logic                parity_err
`endif
);

  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
`ifdef DMEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        WCNT_INIT = 3'(WAIT_STATES);

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [2:0]          r_wcnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wren;
  logic [NB-1:0]       r_be;
  logic [DATA_W-1:0]   r_din;
  logic                w_access;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [NB-1:0]       w_wbe;
  logic [NB*LANE_W-1:0] w_wdata, w_rdata;
  logic [DATA_W-1:0]   w_cur, w_merged;
`ifdef DMEM_PARITY_EN
  logic                r_flip;
  logic                w_perr;
`endif

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= ST_CLEAR;
    else       r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next   = r_state;
    ready    = 1'b0;
    w_access = 1'b0;
    case (r_state)
      ST_CLEAR: if (r_clr_cnt == CLR_LAST) w_next = ST_IDLE;
      ST_IDLE: begin
        ready = 1'b1;
        if (req) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wcnt == 3'd0) begin
          w_access = 1'b1;
          w_next   = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_CLEAR;
    endcase
  end

  // Clear counter, wait counter and request capture.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_clr_cnt <= '0;
      r_wcnt    <= 3'd0;
    end else begin
      // Wraps back to 0 after the last word, ready for the next reset.
      if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_state == ST_IDLE && req) begin
        r_addr <= Address;
        r_wren <= wren;
        r_be   <= be;
        r_din  <= Din;
`ifdef DMEM_PARITY_EN
        r_flip <= par_flip;
`endif
        r_wcnt <= WCNT_INIT;
      end else if (r_state == ST_WAIT && r_wcnt != 3'd0) begin
        r_wcnt <= r_wcnt - 1'b1;
      end
    end
  end

  // Lane data: current word, byte merge, write data and parity check.
  always_comb begin
    w_cur    = '0;
    w_merged = '0;
    w_wdata  = '0;
`ifdef DMEM_PARITY_EN
    w_perr   = 1'b0;
`endif
    for (int i = 0; i < NB; i++) begin
      w_cur[8*i +: 8]    = w_rdata[i*LANE_W +: 8];
      w_merged[8*i +: 8] = r_be[i] ? r_din[8*i +: 8] : w_cur[8*i +: 8];
      if (r_state != ST_CLEAR) w_wdata[i*LANE_W +: 8] = r_din[8*i +: 8];
`ifdef DMEM_PARITY_EN
      if (r_state != ST_CLEAR)
        w_wdata[i*LANE_W + 8] = byte_parity(r_din[8*i +: 8]) ^ ((i == 0) && r_flip);
      if (w_rdata[i*LANE_W + 8] != byte_parity(w_cur[8*i +: 8])) w_perr = 1'b1;
`endif
    end
  end

  // A write lands only on the access edge; reset on that edge discards it.
  assign w_we    = !Reset && ((r_state == ST_CLEAR) || (w_access && r_wren));
  assign w_waddr = (r_state == ST_CLEAR) ? r_clr_cnt : r_addr;
  assign w_wbe   = (r_state == ST_CLEAR) ? {NB{1'b1}} : r_be;

  data_mem_array #(
    .ADDR_W (ADDR_W),
    .NBYTES (NB),
    .LANE_W (LANE_W)
  ) u_array (
    .Clock (Clock),
    .we    (w_we),
    .waddr (w_waddr),
    .wbe   (w_wbe),
    .wdata (w_wdata),
    .raddr (r_addr),
    .rdata (w_rdata)
  );

  // Completion pulse and returned data; Q holds between acks.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ack <= 1'b0;
      Q   <= '0;
`ifdef DMEM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      ack <= w_access;
      if (w_access) Q <= r_wren ? w_merged : w_cur;
`ifdef DMEM_PARITY_EN
      parity_err <= w_access && !r_wren && w_perr;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Self-checking bench for data_mem_ctrl: one instance with
//            WAIT_STATES=1 (table vectors, reset abort, parity) and one with
//            WAIT_STATES=0 (back-to-back throughput).
// Options  : DMEM_PARITY_EN - also exercises par_flip / parity_err.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req, wren, ready, ack;
  logic [1:0]  be;
  logic [3:0]  addr;
  logic [15:0] din, q;
  logic        req0, wren0, ready0, ack0;
  logic [1:0]  be0;
  logic [3:0]  addr0;
  logic [15:0] din0, q0;
`ifdef DMEM_PARITY_EN
  logic        par_flip, perr, par_flip0, perr0, last_perr;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 Clock = ~Clock;

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(4), .WAIT_STATES(1)) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .wren(wren), .be(be),
    .Address(addr), .Din(din), .ready(ready), .ack(ack), .Q(q)
`ifdef DMEM_PARITY_EN
    , .par_flip(par_flip), .parity_err(perr)
`endif
  );

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(4), .WAIT_STATES(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .req(req0), .wren(wren0), .be(be0),
    .Address(addr0), .Din(din0), .ready(ready0), .ack(ack0), .Q(q0)
`ifdef DMEM_PARITY_EN
    , .par_flip(par_flip0), .parity_err(perr0)
`endif
  );

  typedef struct {
    bit          wr;
    logic [1:0]  bev;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] exp_q;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One complete access on the selected instance: wait for ready, present
  // the request for the accepting edge, then measure edges until ack.
  task automatic access(input bit sel, input bit wr, input logic [1:0] bev,
                        input logic [3:0] a, input logic [15:0] d, input bit flip,
                        input int exp_lat, input logic [15:0] exp_q, input string nm);
    int guard;
    int lat;
    guard = 0;
    @(negedge Clock);
    while (!(sel ? ready0 : ready) && guard < 50) begin
      @(negedge Clock);
      guard++;
    end
    if (guard >= 50) begin
      check({nm, " ready timeout"}, sel ? ready0 : ready, 1);
      return;
    end
    if (sel) begin
      req0 = 1'b1; wren0 = wr; be0 = bev; addr0 = a; din0 = d;
    end else begin
      req = 1'b1; wren = wr; be = bev; addr = a; din = d;
`ifdef DMEM_PARITY_EN
      par_flip = flip;
`endif
    end
    @(posedge Clock); #1;
    req = 1'b0; req0 = 1'b0;
`ifdef DMEM_PARITY_EN
    par_flip = 1'b0;
`endif
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clock); #1;
      if (sel ? ack0 : ack) begin
        lat = k;
        break;
      end
    end
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " Q"}, sel ? q0 : q, exp_q);
`ifdef DMEM_PARITY_EN
    last_perr = perr;
`endif
    if (flip) lat = lat;
  endtask

  initial begin
    int n;
    int nk, na;
    int acc[2];
    int akt[2];
    logic [15:0] akq[2];
    bit rdy;

    vt[0] = '{1'b1, 2'b11, 4'd3,  16'hBEEF, 16'hBEEF};
    vt[1] = '{1'b0, 2'b00, 4'd3,  16'h0000, 16'hBEEF};
    vt[2] = '{1'b1, 2'b01, 4'd3,  16'h1234, 16'hBE34};
    vt[3] = '{1'b1, 2'b00, 4'd3,  16'h5678, 16'hBE34};
    vt[4] = '{1'b0, 2'b00, 4'd3,  16'h0000, 16'hBE34};
    vt[5] = '{1'b1, 2'b10, 4'd15, 16'hA5C3, 16'hA500};
    vt[6] = '{1'b0, 2'b00, 4'd15, 16'h0000, 16'hA500};
    vt[7] = '{1'b0, 2'b00, 4'd7,  16'h0000, 16'h0000};
    vt[8] = '{1'b1, 2'b11, 4'd0,  16'h0011, 16'h0011};
    vt[9] = '{1'b0, 2'b00, 4'd0,  16'h0000, 16'h0011};

    Reset = 1'b1;
    req = 1'b0; wren = 1'b0; be = 2'b00; addr = 4'd0; din = 16'h0;
    req0 = 1'b0; wren0 = 1'b0; be0 = 2'b00; addr0 = 4'd0; din0 = 16'h0;
`ifdef DMEM_PARITY_EN
    par_flip = 1'b0; par_flip0 = 1'b0; last_perr = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("reset ready", ready, 0);
    check("reset ack", ack, 0);
    check("reset Q", q, 0);
    check("reset ready0", ready0, 0);

    // Clear sweep length after reset release
    @(negedge Clock);
    Reset = 1'b0;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge Clock); #1;
      n++;
    end
    check("clear cycles", n, 16);
    check("ready0 after clear", ready0, 1);

    for (int a = 0; a < 16; a++)
      access(1'b0, 1'b0, 2'b00, 4'(a), 16'h0, 1'b0, 2, 16'h0000, $sformatf("clr_rd[%0d]", a));

    // Table vectors
    for (int i = 0; i < 10; i++)
      access(1'b0, vt[i].wr, vt[i].bev, vt[i].a, vt[i].d, 1'b0, 2, vt[i].exp_q,
             $sformatf("vec[%0d]", i));

    // Q holds after ack with no new request
    repeat (4) @(posedge Clock);
    #1;
    check("Q hold", q, 16'h0011);
    check("ack idle", ack, 0);

    // Reset during WAIT of a write aborts it
    @(negedge Clock);
    req = 1'b1; wren = 1'b1; be = 2'b11; addr = 4'd5; din = 16'hAAAA;
    @(posedge Clock); #1;
    req = 1'b0;
    check("abort in WAIT", ready, 0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("abort no ack", ack, 0);
    check("abort Q reset", q, 0);
    @(negedge Clock);
    Reset = 1'b0;
    n = 0;
    nk = 0;
    while (!ready && n < 40) begin
      @(posedge Clock); #1;
      n++;
      if (ack) nk++;
    end
    check("abort clear cycles", n, 16);
    check("abort ack count", nk, 0);
    access(1'b0, 1'b0, 2'b00, 4'd5, 16'h0, 1'b0, 2, 16'h0000, "abort rd5");
    access(1'b0, 1'b0, 2'b00, 4'd3, 16'h0, 1'b0, 2, 16'h0000, "abort rd3");

    // Zero wait states: preload, then back-to-back reads of 15 and 0
    access(1'b1, 1'b1, 2'b11, 4'd15, 16'h7E81, 1'b0, 1, 16'h7E81, "ws0 wr15");
    access(1'b1, 1'b1, 2'b11, 4'd0,  16'h1C3D, 1'b0, 1, 16'h1C3D, "ws0 wr0");
    na = 0; nk = 0;
    acc[0] = -100; acc[1] = -100; akt[0] = -100; akt[1] = -100;
    akq[0] = 16'hxxxx; akq[1] = 16'hxxxx;
    @(negedge Clock);
    req0 = 1'b1; wren0 = 1'b0; addr0 = 4'd15;
    for (int e = 1; e <= 30 && nk < 2; e++) begin
      rdy = ready0;
      @(posedge Clock); #1;
      if (rdy && req0 && na < 2) begin
        acc[na] = e;
        na++;
        if (na == 1) addr0 = 4'd0;
        else req0 = 1'b0;
      end
      if (ack0 && nk < 2) begin
        akt[nk] = e;
        akq[nk] = q0;
        nk++;
      end
      @(negedge Clock);
    end
    req0 = 1'b0;
    check("b2b ack count", nk, 2);
    check("b2b latency 15", akt[0] - acc[0], 1);
    check("b2b latency 0", akt[1] - acc[1], 1);
    check("b2b accept spacing", acc[1] - acc[0], 3);
    check("b2b Q 15", akq[0], 16'h7E81);
    check("b2b Q 0", akq[1], 16'h1C3D);

`ifdef DMEM_PARITY_EN
    // Corrupted byte-0 parity is reported on the read ack only
    access(1'b0, 1'b1, 2'b11, 4'd2, 16'h00FF, 1'b1, 2, 16'h00FF, "par wr flip");
    check("par wr flip perr", last_perr, 0);
    access(1'b0, 1'b0, 2'b00, 4'd2, 16'h0, 1'b0, 2, 16'h00FF, "par rd bad");
    check("par rd bad perr", last_perr, 1);
    @(posedge Clock); #1;
    check("par perr one cycle", perr, 0);
    access(1'b0, 1'b1, 2'b11, 4'd2, 16'h00FF, 1'b0, 2, 16'h00FF, "par wr good");
    check("par wr good perr", last_perr, 0);
    access(1'b0, 1'b0, 2'b00, 4'd2, 16'h0, 1'b0, 2, 16'h00FF, "par rd good");
    check("par rd good perr", last_perr, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
